// File: rtl/column_scheduler_pkg.sv
// Shared constants and helpers for the falling-letter column scheduler.
// Column index type, LFSR seed/taps and the level ceiling live here.
package column_scheduler_pkg;

    localparam int unsigned NUM_COLS  = 3;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam logic [3:0]  LEVEL_MAX = 4'd15;

    typedef logic [1:0] col_idx_t;

    function automatic col_idx_t next_col(input col_idx_t c);
        if (c >= col_idx_t'(NUM_COLS - 1)) begin
            return '0;
        end
        return c + col_idx_t'(1);
    endfunction

    // x^8+x^6+x^5+x^4+1; the all-zero lock-up state is escaped by reseeding
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        if (v == 8'h00) begin
            return LFSR_SEED;
        end
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/column_scheduler_drop_tick_gen.sv
// Fall-step timebase: derives the level from the score and paces the
// shared tick, with the period re-sampled only when the counter wraps.
module drop_tick_gen
    import column_scheduler_pkg::*;
#(
    parameter int unsigned BASE_PERIOD  = 25_000_000,
    parameter int unsigned PERIOD_DEC   = 2_000_000,
    parameter int unsigned MIN_PERIOD   = 5_000_000,
    parameter int unsigned LEVEL_POINTS = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic [7:0] i_score,
    output logic       o_tick,
    output logic [3:0] o_level
);

    logic [3:0]  r_level;
    logic [31:0] r_count;
    logic [31:0] r_period;

    logic [31:0] w_quot;
    logic [3:0]  w_level;
    logic        w_wrap;

    // Clamp before subtracting so deep levels cannot wrap below zero
    function automatic logic [31:0] period_for(input logic [3:0] lvl);
        logic [31:0] dec;
        dec = 32'(lvl) * PERIOD_DEC;
        if (BASE_PERIOD > MIN_PERIOD + dec) begin
            return BASE_PERIOD - dec;
        end
        return MIN_PERIOD;
    endfunction

    assign w_quot  = {24'd0, i_score} / LEVEL_POINTS;
    assign w_level = (w_quot > 32'(LEVEL_MAX)) ? LEVEL_MAX : w_quot[3:0];

    assign w_wrap  = (r_count == r_period - 32'd1);
    assign o_tick  = i_run & w_wrap;
    assign o_level = r_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level  <= '0;
            r_count  <= '0;
            r_period <= period_for(4'd0);
        end else begin
            r_level <= w_level;
            if (o_tick) begin
                r_count  <= '0;
                r_period <= period_for(r_level);
            end else if (i_run) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/column_scheduler.sv
// Column sequencer: turns the drop tick into per-column step pulses and
// round-robin spawns of LFSR letters into idle columns.
module column_scheduler
    import column_scheduler_pkg::*;
#(
    parameter int unsigned BASE_PERIOD  = 25_000_000,
    parameter int unsigned PERIOD_DEC   = 2_000_000,
    parameter int unsigned MIN_PERIOD   = 5_000_000,
    parameter int unsigned LEVEL_POINTS = 8,
    parameter int unsigned SPAWN_GAP    = 10
) (
    input  logic                clock,
    input  logic                reset_signal,
    input  logic                run,
    input  logic [7:0]          score,
    input  logic [NUM_COLS-1:0] col_active,
    output logic [NUM_COLS-1:0] step,
    output logic [NUM_COLS-1:0] spawn,
    output logic [7:0]          spawn_letter,
    output logic [3:0]          level
);

    localparam int unsigned GAP_W = $clog2(SPAWN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SPAWN_GAP);
    localparam logic [GAP_W-1:0] GAP_THR = GAP_W'(SPAWN_GAP - 1);

    logic [NUM_COLS-1:0] r_step;
    logic [NUM_COLS-1:0] r_spawn;
    logic [7:0]          r_letter;
    logic [7:0]          r_lfsr;
    logic [GAP_W-1:0]    r_gap;
    col_idx_t            r_ptr;

    logic                w_tick;
    logic [3:0]          w_level;
    logic                w_found;
    col_idx_t            w_sel;
    col_idx_t            w_cand;
    logic                w_gap_ok;
    logic                w_spawn_en;
    logic [NUM_COLS-1:0] w_spawn_vec;

    drop_tick_gen #(
        .BASE_PERIOD  (BASE_PERIOD),
        .PERIOD_DEC   (PERIOD_DEC),
        .MIN_PERIOD   (MIN_PERIOD),
        .LEVEL_POINTS (LEVEL_POINTS)
    ) u_tick (
        .i_clk   (clock),
        .i_rst   (reset_signal),
        .i_run   (run),
        .i_score (score),
        .o_tick  (w_tick),
        .o_level (w_level)
    );

    // First idle column after the last one spawned, wrapping round
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = next_col(r_ptr);
        for (int k = 0; k < int'(NUM_COLS); k++) begin
            if (!w_found && !col_active[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
            w_cand = next_col(w_cand);
        end
    end

    // The tick being decided counts toward the gap, so a spawn is allowed
    // on the SPAWN_GAP-th tick after the previous one
    assign w_gap_ok    = (r_gap >= GAP_THR);
    assign w_spawn_en  = w_tick & w_gap_ok & w_found;
    assign w_spawn_vec = w_spawn_en ? (NUM_COLS'(1) << w_sel) : '0;

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_step   <= '0;
            r_spawn  <= '0;
            r_letter <= '0;
            r_lfsr   <= LFSR_SEED;
            r_gap    <= GAP_MAX;
            r_ptr    <= col_idx_t'(NUM_COLS - 1);
        end else begin
            r_lfsr  <= lfsr_next(r_lfsr);
            r_step  <= '0;
            r_spawn <= '0;
            if (w_tick) begin
                r_step  <= col_active & ~w_spawn_vec;
                r_spawn <= w_spawn_vec;
                if (w_spawn_en) begin
                    r_letter <= r_lfsr;
                    r_ptr    <= w_sel;
                    r_gap    <= '0;
                end else if (r_gap < GAP_MAX) begin
                    r_gap <= r_gap + GAP_W'(1);
                end
            end
        end
    end

    assign step         = r_step;
    assign spawn        = r_spawn;
    assign spawn_letter = r_letter;
    assign level        = w_level;

endmodule

// File: tb/tb_column_scheduler.sv
// Directed bench for column_scheduler with scaled-down timing and an
// event scoreboard of expected step/spawn pulses.
module tb_column_scheduler;

    logic       clock = 1'b0;
    logic       reset_signal;
    logic       run;
    logic [7:0] score;
    logic [2:0] col_active;
    logic [2:0] step;
    logic [2:0] spawn;
    logic [7:0] spawn_letter;
    logic [3:0] level;

    typedef struct {
        int       cyc;
        logic [2:0] st;
        logic [2:0] sp;
    } ev_t;

    ev_t        q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] last_letter = 8'h00;

    column_scheduler #(
        .BASE_PERIOD  (10),
        .PERIOD_DEC   (2),
        .MIN_PERIOD   (4),
        .LEVEL_POINTS (4),
        .SPAWN_GAP    (3)
    ) dut (
        .clock        (clock),
        .reset_signal (reset_signal),
        .run          (run),
        .score        (score),
        .col_active   (col_active),
        .step         (step),
        .spawn        (spawn),
        .spawn_letter (spawn_letter),
        .level        (level)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] ref_lfsr(input logic [7:0] v);
        logic fb;
        if (v == 8'h00) return 8'hA5;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [2:0] st,
                        input logic [2:0] sp);
        ev_t e;
        e.cyc = c;
        e.st  = st;
        e.sp  = sp;
        q.push_back(e);
    endtask

    task automatic cycle(input int n);
        logic [7:0] pre;
        ev_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            pre    = m_lfsr;
            m_lfsr = reset_signal ? 8'hA5 : ref_lfsr(m_lfsr);
            cyc++;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("step", 32'(step), 32'(e.st));
                chk("spawn", 32'(spawn), 32'(e.sp));
                if (e.sp != 3'b000) begin
                    chk("letter", 32'(spawn_letter), 32'(pre));
                    last_letter = pre;
                end
            end else begin
                chk("idle_step", 32'(step), 32'd0);
                chk("idle_spawn", 32'(spawn), 32'd0);
            end
        end
    endtask

    initial begin
        reset_signal = 1'b1;
        run          = 1'b0;
        score        = 8'd0;
        col_active   = 3'b000;
        cycle(3);
        chk("rst_letter", 32'(spawn_letter), 32'd0);
        chk("rst_level", 32'(level), 32'd0);

        // first spawn to column 0, then round-robin with gap of 3 ticks
        reset_signal = 1'b0;
        run          = 1'b1;
        push(cyc + 10, 3'b000, 3'b001);
        for (int k = 2; k <= 7; k++) begin
            push(cyc + 10 * k, 3'b001,
                 (k == 4) ? 3'b010 : ((k == 7) ? 3'b100 : 3'b000));
        end
        cycle(10);
        col_active = 3'b001;
        cycle(60);

        // level 3 shortens the period, but only from the next wrap
        score      = 8'd12;
        col_active = 3'b111;
        chk("level_old", 32'(level), 32'd0);
        cycle(1);
        chk("level_3", 32'(level), 32'd3);
        for (int k = 0; k < 6; k++) begin
            push(83 + 4 * k, 3'b111, 3'b000);
        end
        cycle(17);
        score = 8'd40;
        cycle(1);
        chk("level_10", 32'(level), 32'd10);
        cycle(14);

        // column 1 goes idle in the tick cycle itself
        col_active = 3'b101;
        push(107, 3'b101, 3'b010);
        cycle(1);
        col_active = 3'b111;
        score      = 8'd0;
        push(111, 3'b111, 3'b000);
        cycle(4);

        // freeze at count 6 for 50 cycles
        push(171, 3'b111, 3'b000);
        cycle(6);
        run = 1'b0;
        cycle(50);
        chk("letter_hold", 32'(spawn_letter), 32'(last_letter));
        run = 1'b1;
        cycle(4);

        // reset lands in a tick cycle that would otherwise spawn
        col_active = 3'b000;
        score      = 8'd20;
        cycle(4);
        chk("level_5", 32'(level), 32'd5);
        cycle(5);
        reset_signal = 1'b1;
        cycle(1);
        chk("rst2_level", 32'(level), 32'd0);
        chk("rst2_letter", 32'(spawn_letter), 32'd0);
        reset_signal = 1'b0;
        push(191, 3'b000, 3'b001);
        push(195, 3'b001, 3'b000);
        push(199, 3'b001, 3'b000);
        cycle(10);
        col_active = 3'b001;
        cycle(4);
        score = 8'd255;
        cycle(1);
        chk("level_max", 32'(level), 32'd15);
        cycle(5);
        chk("events_left", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
